cpu_dma_engine: RTL

Parametrised CPU-bus DMA engine that replaces the ad-hoc OAM DMA counter in the top-level bus logic. It provides cycle-accurate OAM DMA with get/put alternation, halt and alignment cycles, and an optional second channel for DMC sample fetches that steals cycles from a running OAM transfer. It sits between the CPU address/data outputs and the CPU bus mux. When it owns the bus, it drives address, R/W and write data, and holds the CPU via cpu_rdy.

---
 rtl/cpu_dma_engine.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/cpu_dma_engine.sv
// CPU-bus DMA engine: OAM page copy with GET/PUT alternation plus an optional DMC byte-fetch channel.
// All outputs registered (state entered this edge drives the bus next cycle); CPU held via cpu_rdy.
module cpu_dma_engine #(
    parameter int unsigned       ADDR_W       = 16,
    parameter int unsigned       DATA_W       = 8,
    parameter int unsigned       XFER_LEN     = 256,
    parameter logic [ADDR_W-1:0] TRIGGER_ADDR = 16'h4014,
    parameter logic [ADDR_W-1:0] DEST_ADDR    = 16'h2004,
    parameter bit                DMC_EN       = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET_n,
    input  logic              ENABLE,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data_out,
    input  logic              cpu_rw_n,
    input  logic [DATA_W-1:0] bus_data_in,
    input  logic              dmc_req,
    input  logic [ADDR_W-1:0] dmc_addr,
    output logic              cpu_rdy,
    output logic              dma_active,
    output logic [ADDR_W-1:0] dma_addr,
    output logic              dma_rw_n,
    output logic [DATA_W-1:0] dma_data_out,
    output logic              dmc_ack,
    output logic [DATA_W-1:0] dmc_data
);

    localparam int unsigned IDX_W = (XFER_LEN > 2) ? $clog2(XFER_LEN) : 1;
    localparam int unsigned LO_W  = ADDR_W - DATA_W;
    localparam logic        GET   = 1'b0;
    localparam logic        PUT   = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE, S_HALT, S_DUMMY, S_ALIGN, S_OAM_RD, S_OAM_WR, S_DMC_RD
    } state_t;

    state_t            r_state, w_state_nx;
    logic              r_parity;
    logic [DATA_W-1:0] r_page, w_page_nx;
    logic [IDX_W-1:0]  r_idx, w_idx_nx;
    logic              r_oam_pend, w_oam_pend_nx;
    logic              r_dmc_pend, w_dmc_pend_nx;

    logic              r_cpu_rdy;
    logic              r_dma_active;
    logic [ADDR_W-1:0] r_dma_addr, w_addr_nx;
    logic              r_dma_rw_n;
    logic [DATA_W-1:0] r_dma_data_out, w_data_nx;
    logic              r_dmc_ack;
    logic [DATA_W-1:0] r_dmc_data;

    logic              w_dmc_req;
    logic              w_trigger;
    logic              w_next_get;
    logic              w_last;
    logic              w_active_nx;
    logic [LO_W-1:0]   w_lo;

    assign w_dmc_req  = DMC_EN && dmc_req;
    assign w_trigger  = !cpu_rw_n && (cpu_addr == TRIGGER_ADDR);
    assign w_next_get = (r_parity == PUT);
    assign w_last     = (r_idx == IDX_W'(XFER_LEN - 1));

    always_comb begin : next_state
        w_state_nx    = r_state;
        w_page_nx     = r_page;
        w_idx_nx      = r_idx;
        w_oam_pend_nx = r_oam_pend;
        w_dmc_pend_nx = r_dmc_pend;
        case (r_state)
            S_IDLE: begin
                if (w_trigger) begin
                    w_page_nx     = cpu_data_out;
                    w_idx_nx      = '0;
                    w_oam_pend_nx = 1'b1;
                end
                if (w_dmc_req) begin
                    w_dmc_pend_nx = 1'b1;
                end
                if (w_trigger || w_dmc_req) begin
                    w_state_nx = S_HALT;
                end
            end
            // A pending DMC byte always goes first, through the dummy cycle.
            S_HALT:   w_state_nx = r_dmc_pend ? S_DUMMY : (w_next_get ? S_OAM_RD : S_ALIGN);
            S_DUMMY:  w_state_nx = w_next_get ? S_DMC_RD : S_ALIGN;
            S_ALIGN:  w_state_nx = r_dmc_pend ? S_DMC_RD : S_OAM_RD;
            S_OAM_RD: w_state_nx = S_OAM_WR;
            S_OAM_WR: begin
                if (w_last) begin
                    w_oam_pend_nx = 1'b0;
                end else begin
                    w_idx_nx = r_idx + 1'b1;
                end
                if (w_dmc_req) begin
                    w_dmc_pend_nx = 1'b1;
                    w_state_nx    = S_DMC_RD;
                end else begin
                    w_state_nx = w_last ? S_IDLE : S_OAM_RD;
                end
            end
            // After a steal the following PUT cycle realigns before OAM resumes.
            S_DMC_RD: begin
                w_dmc_pend_nx = 1'b0;
                w_state_nx    = r_oam_pend ? S_ALIGN : S_IDLE;
            end
            default:  w_state_nx = S_IDLE;
        endcase
    end

    assign w_lo        = LO_W'(w_idx_nx);
    assign w_active_nx = (w_state_nx == S_OAM_RD) || (w_state_nx == S_OAM_WR) ||
                         (w_state_nx == S_DMC_RD);

    always_comb begin : next_outputs
        w_addr_nx = r_dma_addr;
        w_data_nx = r_dma_data_out;
        case (w_state_nx)
            S_OAM_RD: w_addr_nx = {w_page_nx, w_lo};
            S_OAM_WR: begin
                w_addr_nx = DEST_ADDR;
                w_data_nx = bus_data_in;
            end
            S_DMC_RD: w_addr_nx = dmc_addr;
            default:  ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state        <= S_IDLE;
            r_parity       <= GET;
            r_page         <= '0;
            r_idx          <= '0;
            r_oam_pend     <= 1'b0;
            r_dmc_pend     <= 1'b0;
            r_cpu_rdy      <= 1'b1;
            r_dma_active   <= 1'b0;
            r_dma_addr     <= '0;
            r_dma_rw_n     <= 1'b1;
            r_dma_data_out <= '0;
            r_dmc_ack      <= 1'b0;
            r_dmc_data     <= '0;
        end else if (ENABLE) begin
            r_state        <= w_state_nx;
            r_parity       <= ~r_parity;
            r_page         <= w_page_nx;
            r_idx          <= w_idx_nx;
            r_oam_pend     <= w_oam_pend_nx;
            r_dmc_pend     <= w_dmc_pend_nx;
            r_cpu_rdy      <= (w_state_nx == S_IDLE);
            r_dma_active   <= w_active_nx;
            r_dma_addr     <= w_addr_nx;
            r_dma_rw_n     <= (w_state_nx != S_OAM_WR);
            r_dma_data_out <= w_data_nx;
            r_dmc_ack      <= (r_state == S_DMC_RD);
            if (r_state == S_DMC_RD) begin
                r_dmc_data <= bus_data_in;
            end
        end
    end

    assign cpu_rdy      = r_cpu_rdy;
    assign dma_active   = r_dma_active;
    assign dma_addr     = r_dma_addr;
    assign dma_rw_n     = r_dma_rw_n;
    assign dma_data_out = r_dma_data_out;
    assign dmc_ack      = r_dmc_ack;
    assign dmc_data     = r_dmc_data;

endmodule
